// File: rtl/pkt_ext_mem_sched.sv
// Arbiter for the single-port external packet memory: admits/drops packets at
// SOP, locks the memory to the writer per packet and offers read slots in bursts.
module pkt_ext_mem_sched #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 12,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_req,
  input  logic              enq_in_sop,
  input  logic              enq_in_eop,
  input  logic [DATA_W-1:0] enq_wr_data_i,
  input  logic [LEN_W-1:0]  enq_pck_len_i,
  output logic              enq_ready,
  input  logic              deq_req,
  output logic              deq_gnt,
  output logic [DATA_W-1:0] deq_rd_data_o,
  output logic              data_valid,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W:0]   wr_lvl,
  output logic              ram_full,
  output logic              ram_empty,
  output logic              ram_overflow,
  output logic              ram_underflow,
  output logic              enq_packet_drop,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam int CW   = (LEN_W > ADDR_W + 1) ? LEN_W : ADDR_W + 1;
  localparam int BC_W = $clog2(BURST_MAX + 1);
  localparam logic [BC_W-1:0] BURST_LIM = BC_W'(BURST_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_PKT  = 2'd1,
    YIELD   = 2'd2,
    WR_DROP = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   lvl;
  logic [BC_W-1:0]   burst_cnt;
  logic [BC_W-1:0]   burst_nxt;
  logic              last_gnt_wr;
  logic              rd_pend;

  logic              sop_req;
  logic              eop_req;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   free_words;
  logic [CW-1:0]     len_ext;
  logic [CW-1:0]     free_ext;
  logic              admit;
  logic              idle_wr_sel;
  logic              rd_gnt;
  logic              wr_do;
  logic              rd_do;
  logic              enq_rdy;
  logic              ovf_ev;
  logic              unf_ev;
  logic              drop_ev;

  assign sop_req    = enq_req & enq_in_sop;
  assign eop_req    = enq_req & enq_in_eop;
  assign empty      = (lvl == '0);
  assign full       = (lvl == DEPTH_L);
  assign free_words = DEPTH_L - lvl;
  assign len_ext    = CW'(enq_pck_len_i);
  assign free_ext   = CW'(free_words);
  assign admit      = (enq_pck_len_i != '0) && (len_ext <= free_ext);

  // Handshake: an enqueue word is consumed (written or discarded) in any cycle
  // where enq_req and enq_ready are both high; a read is consumed whenever
  // deq_gnt is high, and deq_gnt is only ever raised while deq_req is high.
  always_comb begin
    idle_wr_sel = 1'b0;
    rd_gnt      = 1'b0;
    wr_do       = 1'b0;
    enq_rdy     = 1'b0;
    ovf_ev      = 1'b0;
    drop_ev     = 1'b0;
    burst_nxt   = burst_cnt;
    if (!rst) begin
      case (state)
        IDLE: begin
          // On a tie the side that did not win last time takes the memory.
          idle_wr_sel = sop_req & (~deq_req | ~last_gnt_wr);
          rd_gnt      = deq_req & ~idle_wr_sel;
          enq_rdy     = ~rd_gnt;
          if (idle_wr_sel) begin
            wr_do   = admit;
            drop_ev = ~admit;
          end
        end
        WR_PKT: begin
          enq_rdy = 1'b1;
          if (enq_req) begin
            ovf_ev = full;
            wr_do  = ~full;
            if (burst_cnt != BURST_LIM) begin
              burst_nxt = burst_cnt + BC_W'(1);
            end
          end
        end
        YIELD: begin
          rd_gnt = deq_req;
        end
        WR_DROP: begin
          enq_rdy = 1'b1;
          rd_gnt  = deq_req;
        end
        default: begin
          enq_rdy = 1'b0;
        end
      endcase
    end
  end

  assign rd_do  = rd_gnt & ~empty;
  assign unf_ev = rd_gnt & empty;

  assign enq_ready = enq_rdy;
  assign deq_gnt   = rd_gnt;
  assign mem_wr_en = wr_do;
  assign mem_rd_en = rd_do;
  assign mem_addr  = wr_do ? wr_ptr : rd_ptr;
  assign mem_wdata = wr_do ? enq_wr_data_i : '0;
  assign wr_lvl    = lvl;
  assign ram_full  = full;
  assign ram_empty = empty;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      lvl             <= '0;
      burst_cnt       <= '0;
      last_gnt_wr     <= 1'b0;
      rd_pend         <= 1'b0;
      deq_rd_data_o   <= '0;
      data_valid      <= 1'b0;
      ram_overflow    <= 1'b0;
      ram_underflow   <= 1'b0;
      enq_packet_drop <= 1'b0;
    end else begin
      if (wr_do) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_do) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (wr_do && !rd_do) begin
        lvl <= lvl + (ADDR_W + 1)'(1);
      end else if (rd_do && !wr_do) begin
        lvl <= lvl - (ADDR_W + 1)'(1);
      end

      ram_overflow    <= ovf_ev;
      ram_underflow   <= unf_ev;
      enq_packet_drop <= drop_ev;

      // Read data returns one cycle after mem_rd_en and is registered once more.
      rd_pend    <= rd_do;
      data_valid <= rd_pend;
      if (rd_pend) deq_rd_data_o <= mem_rdata;

      case (state)
        IDLE: begin
          if (idle_wr_sel) begin
            last_gnt_wr <= 1'b1;
            if (admit) begin
              burst_cnt <= BC_W'(1);
              if (!enq_in_eop) state <= WR_PKT;
            end else if (!enq_in_eop) begin
              state <= WR_DROP;
            end
          end else if (rd_gnt) begin
            last_gnt_wr <= 1'b0;
          end
        end
        WR_PKT: begin
          burst_cnt <= burst_nxt;
          if (eop_req) begin
            state       <= IDLE;
            last_gnt_wr <= 1'b1;
          end else if (burst_nxt == BURST_LIM && deq_req) begin
            state <= YIELD;
          end
        end
        YIELD: begin
          burst_cnt <= '0;
          state     <= WR_PKT;
        end
        WR_DROP: begin
          if (eop_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_ext_mem_sched.sv
// Bench for pkt_ext_mem_sched: directed scenarios plus random packet traffic,
// scored against a queue model of the stored words and a memory model.
module tb_pkt_ext_mem_sched;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int LEN_W     = 12;
  localparam int BURST_MAX = 8;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enq_req = 1'b0;
  logic              enq_in_sop = 1'b0;
  logic              enq_in_eop = 1'b0;
  logic [DATA_W-1:0] enq_wr_data_i = '0;
  logic [LEN_W-1:0]  enq_pck_len_i = '0;
  logic              enq_ready;
  logic              deq_req = 1'b0;
  logic              deq_gnt;
  logic [DATA_W-1:0] deq_rd_data_o;
  logic              data_valid;
  logic              mem_wr_en;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [ADDR_W:0]   wr_lvl;
  logic              ram_full;
  logic              ram_empty;
  logic              ram_overflow;
  logic              ram_underflow;
  logic              enq_packet_drop;
  logic [1:0]        dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  pkt_ext_mem_sched #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .enq_req(enq_req), .enq_in_sop(enq_in_sop), .enq_in_eop(enq_in_eop),
    .enq_wr_data_i(enq_wr_data_i), .enq_pck_len_i(enq_pck_len_i), .enq_ready(enq_ready),
    .deq_req(deq_req), .deq_gnt(deq_gnt), .deq_rd_data_o(deq_rd_data_o), .data_valid(data_valid),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .wr_lvl(wr_lvl), .ram_full(ram_full), .ram_empty(ram_empty),
    .ram_overflow(ram_overflow), .ram_underflow(ram_underflow),
    .enq_packet_drop(enq_packet_drop), .dbg_state(dbg_state)
  );

  // memory macro model: one-cycle read latency
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // dequeue requester: percentage of cycles with deq_req high
  int deq_pct = 0;
  always @(posedge clk) begin
    #1;
    deq_req = (int'($urandom_range(0, 99)) < deq_pct);
  end

  // scoreboard state
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] due_data[$];
  longint            due_cyc[$];
  longint            cyc = 0;
  int unsigned       exp_wptr = 0;
  int unsigned       exp_rptr = 0;
  bit                in_pkt = 0;
  bit                pkt_admit = 0;
  bit                exp_ovf = 0;
  bit                exp_unf = 0;
  bit                exp_drop = 0;
  int                drop_seen = 0;
  int                ovf_seen = 0;
  int                unf_seen = 0;
  int                dv_seen = 0;
  int                wr_addr_log[$];

  always @(negedge clk) begin : monitor
    int sz;
    bit exp_wr;
    bit exp_rd;
    bit n_ovf;
    bit n_unf;
    bit n_drop;
    cyc++;
    if (rst) begin
      check_eq("rst_enq_ready", enq_ready, 0);
      check_eq("rst_deq_gnt", deq_gnt, 0);
      check_eq("rst_mem_en", {mem_wr_en, mem_rd_en}, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_wr_lvl", wr_lvl, 0);
      check_eq("rst_empty_full", {ram_empty, ram_full}, 2'b10);
      check_eq("rst_data_valid", data_valid, 0);
      check_eq("rst_pulses", {ram_overflow, ram_underflow, enq_packet_drop}, 0);
      check_eq("rst_state_idle", dbg_state, 0);
      exp_q.delete(); due_data.delete(); due_cyc.delete();
      exp_wptr = 0; exp_rptr = 0; in_pkt = 0; pkt_admit = 0;
      exp_ovf = 0; exp_unf = 0; exp_drop = 0;
    end else begin
      sz = exp_q.size();
      if (enq_packet_drop) drop_seen++;
      if (ram_overflow) ovf_seen++;
      if (ram_underflow) unf_seen++;
      if (data_valid) dv_seen++;
      check_eq("drop_pulse", enq_packet_drop, exp_drop);
      check_eq("overflow_pulse", ram_overflow, exp_ovf);
      check_eq("underflow_pulse", ram_underflow, exp_unf);
      check_eq("wr_lvl", wr_lvl, sz);
      check_eq("ram_full", ram_full, sz == DEPTH);
      check_eq("ram_empty", ram_empty, sz == 0);

      if (due_cyc.size() > 0 && due_cyc[0] == cyc) begin
        check_eq("data_valid", data_valid, 1);
        check_eq("rd_data", deq_rd_data_o, due_data[0]);
        void'(due_cyc.pop_front());
        void'(due_data.pop_front());
      end else begin
        check_eq("data_valid_idle", data_valid, 0);
      end

      exp_wr = 0; exp_rd = 0; n_ovf = 0; n_unf = 0; n_drop = 0;
      if (enq_req && enq_ready) begin
        if (!in_pkt) begin
          if (enq_in_sop) begin
            pkt_admit = (enq_pck_len_i != 0) && (int'(enq_pck_len_i) <= DEPTH - sz);
            n_drop = !pkt_admit;
            exp_wr = pkt_admit;
            in_pkt = !enq_in_eop;
          end
        end else begin
          if (pkt_admit) begin
            if (sz == DEPTH) n_ovf = 1;
            else exp_wr = 1;
          end
          if (enq_in_eop) in_pkt = 0;
        end
      end
      check_eq("mem_wr_en", mem_wr_en, exp_wr);
      if (exp_wr) begin
        check_eq("wr_addr", mem_addr, exp_wptr);
        check_eq("wr_data", mem_wdata, enq_wr_data_i);
        wr_addr_log.push_back(int'(mem_addr));
        exp_q.push_back(enq_wr_data_i);
        exp_wptr = (exp_wptr + 1) % DEPTH;
      end

      if (!deq_req) check_eq("gnt_without_req", deq_gnt, 0);
      if (deq_gnt) begin
        exp_rd = (sz > 0) && !exp_wr;
        n_unf = (sz == 0);
      end
      check_eq("mem_rd_en", mem_rd_en, exp_rd);
      if (exp_rd) begin
        check_eq("rd_addr", mem_addr, exp_rptr);
        due_data.push_back(exp_q.pop_front());
        due_cyc.push_back(cyc + 2);
        exp_rptr = (exp_rptr + 1) % DEPTH;
      end
      exp_ovf = n_ovf; exp_unf = n_unf; exp_drop = n_drop;
    end
  end

  // driver tasks (inputs change 1 time unit after the rising edge)
  int stall_cnt;
  int stall_idx[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_packet(input int n_words, input int len, input int gap_pct,
                             input int abort_after, input bit deq_during, input longint base);
    int waits;
    stall_cnt = 0;
    stall_idx.delete();
    for (int i = 0; i < n_words; i++) begin
      if (i == abort_after) return;
      for (int g = 0; g < 3 && gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct; g++) begin
        enq_req = 0;
        tick();
      end
      enq_req       = 1;
      enq_in_sop    = (i == 0);
      enq_in_eop    = (i == n_words - 1);
      enq_wr_data_i = (base < 0) ? DATA_W'($urandom) : DATA_W'(base + i);
      enq_pck_len_i = LEN_W'(len);
      @(negedge clk);
      waits = 0;
      while (!enq_ready && waits < 300) begin
        if (waits == 0) stall_idx.push_back(i);
        stall_cnt++;
        waits++;
        @(negedge clk);
      end
      if (waits >= 300) begin
        check_eq("enq_timeout", 1, 0);
        tick();
        enq_req = 0; enq_in_sop = 0; enq_in_eop = 0;
        return;
      end
      if (deq_during && i == 0) deq_pct = 100;
      if (deq_during && i == n_words - 1) deq_pct = 0;
      tick();
    end
    enq_req = 0; enq_in_sop = 0; enq_in_eop = 0;
  endtask

  task automatic send_stray();
    int waits = 0;
    enq_req = 1; enq_in_sop = 0; enq_in_eop = 0;
    enq_wr_data_i = DATA_W'($urandom);
    @(negedge clk);
    while (!enq_ready && waits < 300) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 300) check_eq("stray_timeout", 1, 0);
    tick();
    enq_req = 0;
  endtask

  task automatic do_reads(input int n);
    int got = 0;
    int waits = 0;
    deq_pct = 100;
    while (got < n && waits < n * 4 + 300) begin
      @(negedge clk);
      if (deq_gnt) got++;
      waits++;
    end
    if (got < n) check_eq("read_timeout", got, n);
    deq_pct = 0;
    tick();
  endtask

  initial begin
    #5000000;
    check_eq("watchdog", 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int pre, d0, o0, u0, v0, n, len;
    repeat (3) tick();
    rst = 0;
    tick();

    // 4-word packet, then read it back
    send_packet(4, 4, 0, -1, 0, 'hA0);
    check_eq("t1_lvl", wr_lvl, 4);
    check_eq("t1_empty", ram_empty, 0);
    do_reads(4);
    repeat (3) tick();
    check_eq("t1_lvl_drained", wr_lvl, 0);
    check_eq("t1_dv_count", dv_seen, 4);

    // burst yield: 4 stored, 20-word packet with deq_req held
    send_packet(4, 4, 0, -1, 0, -1);
    v0 = dv_seen;
    send_packet(20, 20, 0, -1, 1, -1);
    check_eq("t2_stall_cnt", stall_cnt, 2);
    if (stall_idx.size() == 2) begin
      check_eq("t2_yield1_word", stall_idx[0], 8);
      check_eq("t2_yield2_word", stall_idx[1], 16);
    end
    check_eq("t2_lvl", wr_lvl, 22);
    repeat (3) tick();
    check_eq("t2_reads", dv_seen - v0, 2);
    do_reads(22);

    // admission: fill to DEPTH-3, drop len 4, accept len 3 (+1 extra word overflows)
    send_packet(DEPTH - 3, DEPTH - 3, 0, -1, 0, -1);
    check_eq("t3_lvl_fill", wr_lvl, DEPTH - 3);
    d0 = drop_seen;
    send_packet(4, 4, 0, -1, 0, -1);
    tick();
    check_eq("t3_drop_pulse", drop_seen - d0, 1);
    check_eq("t3_lvl_after_drop", wr_lvl, DEPTH - 3);
    o0 = ovf_seen;
    send_packet(4, 3, 0, -1, 0, -1);
    tick();
    check_eq("t3_full", ram_full, 1);
    check_eq("t3_lvl_full", wr_lvl, DEPTH);
    check_eq("t3_overflow", ovf_seen - o0, 1);
    do_reads(DEPTH);

    // read while empty
    repeat (3) tick();
    u0 = unf_seen; v0 = dv_seen;
    do_reads(1);
    repeat (3) tick();
    check_eq("t4_underflow", unf_seen - u0, 1);
    check_eq("t4_no_data", dv_seen - v0, 0);
    check_eq("t4_lvl", wr_lvl, 0);
    check_eq("t4_empty", ram_empty, 1);

    // pointer wrap at 1022
    pre = int'((1022 + DEPTH - exp_wptr) % DEPTH);
    if (pre > 0) begin
      send_packet(pre, pre, 0, -1, 0, -1);
      do_reads(pre);
    end
    wr_addr_log.delete();
    send_packet(4, 4, 0, -1, 0, 'hC0);
    check_eq("t5_addr_cnt", wr_addr_log.size(), 4);
    if (wr_addr_log.size() == 4) begin
      check_eq("t5_addr0", wr_addr_log[0], 1022);
      check_eq("t5_addr1", wr_addr_log[1], 1023);
      check_eq("t5_addr2", wr_addr_log[2], 0);
      check_eq("t5_addr3", wr_addr_log[3], 1);
    end
    do_reads(4);
    repeat (3) tick();

    // reset mid-packet, then tie right after reset goes to the writer
    send_packet(5, 5, 0, 2, 0, -1);
    rst = 1;
    deq_pct = 100;
    repeat (3) tick();
    enq_req = 0;
    wr_addr_log.delete();
    rst = 0;
    send_packet(3, 3, 0, -1, 0, 'hD0);
    check_eq("t6_writer_first", stall_cnt, 0);
    if (wr_addr_log.size() > 0) check_eq("t6_addr0", wr_addr_log[0], 0);
    else check_eq("t6_no_write", 0, 1);
    repeat (6) tick();
    deq_pct = 0;
    repeat (4) tick();

    // random traffic
    for (int p = 0; p < 150; p++) begin
      case ($urandom_range(0, 3))
        0: deq_pct = 0;
        1: deq_pct = 20;
        2: deq_pct = 50;
        default: deq_pct = 90;
      endcase
      if ($urandom_range(0, 9) == 0) send_stray();
      len = $urandom_range(0, 40);
      n = (len == 0) ? 1 : len;
      if ($urandom_range(0, 9) == 0) n = n + $urandom_range(1, 3);
      send_packet(n, len, $urandom_range(0, 30), -1, 0, -1);
    end
    deq_pct = 0;
    tick();
    if (exp_q.size() > 0) do_reads(exp_q.size());
    repeat (5) tick();
    check_eq("end_pending_reads", due_cyc.size(), 0);
    check_eq("end_lvl", wr_lvl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_ext_mem_sched.md
Name: pkt_ext_mem_sched

Overview:
- Schedules the single-port external packet memory between the enqueue (write) path and the dequeue (read) path of the packet processor.
- Admits or drops whole packets at SOP based on free space, and locks the memory to the writer for a packet.
- Inserts read slots every BURST_MAX words so dequeue is not starved.
- Owns the circular write/read pointers, fill level and RAM status flags; sits between the enqueue/dequeue front ends and the memory macro.

Parameters:
- ADDR_W, 10: memory address width; DEPTH = 2**ADDR_W words.
- DATA_W, 32: memory word width.
- LEN_W, 12: packet length field width, in words.
- BURST_MAX, 8: maximum consecutive packet writes before a read slot is offered.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enq_req  in  1  enqueue word valid.
- enq_in_sop  in  1  first word of packet; qualified by enq_req.
- enq_in_eop  in  1  last word of packet; qualified by enq_req.
- enq_wr_data_i  in  DATA_W  enqueue word.
- enq_pck_len_i  in  LEN_W  packet length in words; sampled with enq_req&enq_in_sop.
- enq_ready  out  1  word accepted (written or discarded) this cycle when enq_req=1.
- deq_req  in  1  dequeue read request (level).
- deq_gnt  out  1  read slot granted this cycle.
- deq_rd_data_o  out  DATA_W  read data.
- data_valid  out  1  deq_rd_data_o valid (1-cycle pulse per read).
- mem_wr_en  out  1  memory write strobe.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_rd_en.
- wr_lvl  out  ADDR_W+1  words stored.
- ram_full  out  1  wr_lvl==DEPTH.
- ram_empty  out  1  wr_lvl==0.
- ram_overflow  out  1  pulse: word written while full, discarded.
- ram_underflow  out  1  pulse: read granted while empty.
- enq_packet_drop  out  1  pulse: packet rejected at SOP.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; wr_ptr=rd_ptr=wr_lvl=0; burst_cnt=0.
  - last_gnt=READ, so the first tie goes to the writer.
  - All outputs 0 except ram_empty=1. enq_ready and deq_gnt are forced 0 while rst=1.
  - Reset mid-packet abandons the packet; written words are lost (pointers cleared).
- Datapath timing:
  - mem_wr_en/mem_rd_en/mem_addr/mem_wdata are combinational from state and grants.
  - Writes use address wr_ptr; reads use address rd_ptr.
  - Read granted in cycle N: mem_rd_en=1 in N, mem_rdata valid in N+1, deq_rd_data_o/data_valid registered and visible in N+2.
  - deq_rd_data_o holds its last value when data_valid=0.
- Pointers and level:
  - wr_ptr/rd_ptr advance modulo DEPTH on each real write/read.
  - wr_lvl: +1 per write, -1 per read. Single port, so never both in one cycle.
- IDLE:
  - enq_req&sop and deq_req both pending: alternate using last_gnt.
  - Write chosen, enq_req&sop: if enq_pck_len_i==0 or enq_pck_len_i > DEPTH-wr_lvl, pulse enq_packet_drop, no write, go WR_DROP (stay IDLE if eop in the same cycle). Otherwise write the word, burst_cnt=1, go WR_PKT (stay IDLE if eop). enq_ready=1.
  - enq_req without sop in IDLE: word discarded, enq_ready=1, no flag.
  - Read chosen: deq_gnt=1; if empty, pulse ram_underflow with no mem_rd_en, no data_valid, no level change. enq_ready=0 that cycle.
- WR_PKT:
  - Writer owns memory; enq_ready=1; each enq_req writes one word and increments burst_cnt.
  - Word while full: ram_overflow pulse, word discarded, pointers unchanged.
  - enq_req&eop: go IDLE, last_gnt=WRITE.
  - burst_cnt==BURST_MAX and deq_req and no eop this cycle: go YIELD.
- YIELD (1 cycle):
  - enq_ready=0; deq_gnt=1; read executes (underflow rule as in IDLE).
  - burst_cnt=0; return to WR_PKT.
  - If deq_req has dropped, YIELD is not entered and burst_cnt saturates at BURST_MAX.
- WR_DROP:
  - enq_ready=1; words discarded, no mem_wr_en.
  - deq_req served each cycle (deq_gnt=1).
  - enq_req&eop: go IDLE.
- Flags:
  - ram_full/ram_empty are combinational from wr_lvl.
  - Pulse outputs (ram_overflow, ram_underflow, enq_packet_drop) are registered, 1 cycle after the event.

Test Plan:
- Reset, then 4-word packet (len=4, data 0xA0..0xA3) -> 4 mem_wr_en at addr 0..3, wr_lvl=4, ram_empty=0; four deq_req grants -> data_valid 2 cycles after each grant, data 0xA0..0xA3 in order, wr_lvl=0.
- 20-word packet with deq_req held high, 4 words already stored -> YIELD after words 8 and 16, enq_ready low exactly those 2 cycles, 2 reads interleaved, wr_lvl ends 22.
- wr_lvl=DEPTH-3, SOP with len=4 -> enq_packet_drop pulse, remaining words discarded until EOP, wr_lvl unchanged; next packet with len=3 accepted, ram_full=1.
- deq_req while empty -> deq_gnt=1, ram_underflow pulse, no mem_rd_en, no data_valid, wr_lvl=0.
- DEPTH=1024, wr_ptr=1022, 4-word packet -> addresses 1022,1023,0,1; reads return the words in order across the wrap.
- rst asserted mid-packet (after 2 of 5 words) -> outputs clear immediately, ram_empty=1; following packet written from addr 0.
